// File: rtl/mdu_sequencer_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide sequencer.
// The EX stage drives the master side; the sequencer implements the slave side.
interface mdu_sequencer_if;
    logic        start;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, func, a, b, input  busy, done, dz, hi, lo);
    modport slave  (input  start, func, a, b, output busy, done, dz, hi, lo);
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative MIPS multiply/divide sequencer owning HI/LO: 32-cycle shift-add multiply,
// 32-cycle restoring divide. Define MDU_DIV_EN to build the divide datapath.
module mdu_sequencer (
    input  logic           clk,
    input  logic           rst,
    mdu_sequencer_if.slave bus
);
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_sa, r_sb, r_done;
    logic [31:0] r_mc;           // multiplicand (MUL) or divisor (DIV) magnitude
    logic [31:0] r_p, r_q;       // {product hi, multiplier} or {remainder, dividend/quotient}
    logic [31:0] r_hi, r_lo;
`ifdef MDU_DIV_EN
    logic        r_is_div, r_bz, r_dz;
    logic [32:0] w_rsh;
    logic [31:0] w_diff;
    logic        w_fix_dz;
`endif

    logic        w_is_mul, w_is_div, w_signed, w_acc, w_mt, w_fix_wr;
    logic [31:0] w_amag, w_bmag, w_nxt_p, w_nxt_q, w_fix_hi, w_fix_lo;
    logic [32:0] w_sum;
    logic [63:0] w_prod;

    always_comb begin
        w_is_mul = (bus.func == F_MULT) || (bus.func == F_MULTU);
`ifdef MDU_DIV_EN
        w_is_div = (bus.func == F_DIV) || (bus.func == F_DIVU);
`else
        w_is_div = 1'b0;
`endif
        w_signed = (bus.func == F_MULT) || (bus.func == F_DIV);
        // The completing instruction is still in EX during the done cycle; !done stops a relaunch.
        w_acc    = (r_state == S_IDLE) && bus.start && !r_done && (w_is_mul || w_is_div);
        w_mt     = (r_state == S_IDLE) && bus.start && !r_done &&
                   ((bus.func == F_MTHI) || (bus.func == F_MTLO));
        w_amag   = (w_signed && bus.a[31]) ? -bus.a : bus.a;
        w_bmag   = (w_signed && bus.b[31]) ? -bus.b : bus.b;

        w_sum    = {1'b0, r_p} + (r_q[0] ? {1'b0, r_mc} : 33'd0);
        w_nxt_p  = w_sum[32:1];
        w_nxt_q  = {w_sum[0], r_q[31:1]};
        w_prod   = {r_p, r_q};
        if (r_sa ^ r_sb)
            w_prod = -w_prod;
        w_fix_hi = w_prod[63:32];
        w_fix_lo = w_prod[31:0];
        w_fix_wr = 1'b1;
`ifdef MDU_DIV_EN
        w_fix_dz = 1'b0;
        w_rsh    = {r_p, r_q[31]};
        w_diff   = w_rsh[31:0] - r_mc;
        if (r_is_div) begin
            if (w_rsh >= {1'b0, r_mc}) begin
                w_nxt_p = w_diff;
                w_nxt_q = {r_q[30:0], 1'b1};
            end else begin
                w_nxt_p = w_rsh[31:0];
                w_nxt_q = {r_q[30:0], 1'b0};
            end
            w_fix_lo = (r_sa ^ r_sb) ? -r_q : r_q;
            w_fix_hi = r_sa ? -r_p : r_p;
            w_fix_wr = !r_bz;
            w_fix_dz = r_bz;
        end
`endif
    end

    // NOTE: every register in this block uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_done  <= 1'b0;
            r_mc    <= 32'd0;
            r_p     <= 32'd0;
            r_q     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_bz     <= 1'b0;
            r_dz     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MDU_DIV_EN
            r_dz   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_sa    <= w_signed && bus.a[31];
                        r_sb    <= w_signed && bus.b[31];
                        r_mc    <= w_is_div ? w_bmag : w_amag;
                        r_q     <= w_is_div ? w_amag : w_bmag;
                        r_p     <= 32'd0;
                        r_cnt   <= 6'd0;
                        r_state <= S_RUN;
`ifdef MDU_DIV_EN
                        r_is_div <= w_is_div;
                        r_bz     <= (bus.b == 32'd0);
`endif
                    end else if (w_mt) begin
                        if (bus.func == F_MTHI)
                            r_hi <= bus.a;
                        else
                            r_lo <= bus.a;
                    end
                end
                S_RUN: begin
                    r_p   <= w_nxt_p;
                    r_q   <= w_nxt_q;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (w_fix_wr) begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                    r_done  <= 1'b1;
`ifdef MDU_DIV_EN
                    r_dz    <= w_fix_dz;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE) || w_acc;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
`ifdef MDU_DIV_EN
    assign bus.dz   = r_dz;
`else
    assign bus.dz   = 1'b0;
`endif
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: table of MDU ops with hand-computed HI/LO,
// plus sequences for relaunch suppression, MTHI/MTLO, divide-by-zero and mid-run reset.
module tb_mdu_sequencer;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef struct {
        string       name;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        hold;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    vec_t vecs[$];

    mdu_sequencer_if bus();

    mdu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Launch one MDU op and follow it to its done pulse, checking latency, busy and results.
    task automatic run_op(input vec_t v);
        int  busy_n;
        int  done_c;
        bit  seen;
        busy_n = 0;
        done_c = -1;
        seen   = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = v.f;
        bus.a     = v.a;
        bus.b     = v.b;
        #1;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (c > 0)
                @(negedge clk);
            if (bus.done) begin
                seen   = 1'b1;
                done_c = c;
                check({v.name, " busy_in_done"}, bus.busy, 1'b0);
                check({v.name, " hi"}, bus.hi, v.hi);
                check({v.name, " lo"}, bus.lo, v.lo);
                check({v.name, " dz"}, bus.dz, v.dz);
            end else if (bus.busy) begin
                busy_n++;
            end
        end
        check({v.name, " done_seen"}, seen, 1'b1);
        check({v.name, " done_cycle"}, done_c, 34);
        check({v.name, " busy_cycles"}, busy_n, 34);
        if (v.hold) begin
            @(posedge clk);
            #1 bus.start = 1'b0;
            @(negedge clk);
            check({v.name, " no_relaunch_busy"}, bus.busy, 1'b0);
            check({v.name, " no_relaunch_done"}, bus.done, 1'b0);
        end else begin
            bus.start = 1'b0;
        end
    endtask

    task automatic do_mt(input logic [5:0] f, input logic [31:0] v, input string nm);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = f;
        bus.a     = v;
        bus.b     = 32'h0;
        #1 check({nm, " busy"}, bus.busy, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check({nm, " value"}, (f == F_MTHI) ? bus.hi : bus.lo, v);
        check({nm, " no_done"}, bus.done, 1'b0);
    endtask

    // A func the sequencer must not act on: no busy, no done, HI/LO untouched.
    task automatic ignored_op(input logic [5:0] f, input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = f;
        bus.a     = va;
        bus.b     = vb;
        #1 check({nm, " busy"}, bus.busy, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check({nm, " busy_later"}, bus.busy, 1'b0);
            check({nm, " no_done"}, bus.done, 1'b0);
        end
        check({nm, " hi"}, bus.hi, ehi);
        check({nm, " lo"}, bus.lo, elo);
        bus.start = 1'b0;
    endtask

    initial begin
        int done_n;
        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.func  = 6'h0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;

        vecs.push_back('{"multu_max",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"mult_neg3x5", F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b1});
        vecs.push_back('{"mult_minsq",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"mult_maxxm1", F_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0});
        vecs.push_back('{"multu_min",   F_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
`ifdef MDU_DIV_EN
        vecs.push_back('{"div_neg7by2", F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0});
        vecs.push_back('{"divu_100by7", F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0});
        vecs.push_back('{"div_7byneg2", F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b0});
        vecs.push_back('{"div_minbym1", F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{"divu_maxby1", F_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0});
`endif
        vecs.push_back('{"mult_6x7",    F_MULT,  32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset dz",   bus.dz,   1'b0);
        check("reset hi",   bus.hi,   32'h0);
        check("reset lo",   bus.lo,   32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i]);

        ignored_op(6'b100000, 32'h1, 32'h2, 32'd0, 32'd42, "unknown_func");

        do_mt(F_MTLO, 32'hCAFEF00D, "mtlo");
        do_mt(F_MTHI, 32'h12345678, "mthi");
`ifdef MDU_DIV_EN
        run_op('{"div_by_zero", F_DIV, 32'd5, 32'd0, 32'h12345678, 32'hCAFEF00D, 1'b1, 1'b0});
`else
        ignored_op(F_DIV,  32'd9, 32'd3, 32'h12345678, 32'hCAFEF00D, "div_disabled");
        ignored_op(F_DIVU, 32'd9, 32'd3, 32'h12345678, 32'hCAFEF00D, "divu_disabled");
        check("dz_tied_low", bus.dz, 1'b0);
`endif

        // Reset while a multiply is in flight, after iteration 10 has been taken.
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = F_MULTU;
        bus.a     = 32'hFFFFFFFF;
        bus.b     = 32'hFFFFFFFF;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre_reset busy", bus.busy, 1'b1);
        rst       = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("midrun_reset busy", bus.busy, 1'b0);
        check("midrun_reset hi",   bus.hi,   32'h0);
        check("midrun_reset lo",   bus.lo,   32'h0);
        check("midrun_reset done", bus.done, 1'b0);
        rst    = 1'b0;
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done)
                done_n++;
        end
        check("midrun_reset no_done", done_n, 0);
        check("midrun_reset idle_busy", bus.busy, 1'b0);

        run_op('{"multu_after_rst", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs an iterative shift-add multiply or restoring divide over 32 cycles. It owns the architectural HI/LO registers and raises a stall request to the hazard unit while an operation is in flight. MFHI/MFLO read the `hi`/`lo` outputs directly through the EX result mux.

## Interface
- No parameters; datapath width fixed at 32.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — EX-stage instruction is an opcode-000000 R-type with a valid `func`.
- `func` in 6 — funct field: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO; others ignored.
- `a` in 32 — rs operand (forwarded value).
- `b` in 32 — rt operand (forwarded value).
- `busy` out 1 — stall request to the hazard unit (combinational).
- `done` out 1 — one-cycle pulse; `hi`/`lo` hold the new result this cycle.
- `dz` out 1 — divide-by-zero flag; valid only with `done`.
- `hi` out 32 — HI register.
- `lo` out 32 — LO register.

## Operation
- States: IDLE, RUN, FIX.
- Accepted start (`acc`) = state IDLE & `start` & !`done` & func ∈ {MULT, MULTU, DIV, DIVU}. The `!done` qualifier keeps the completing instruction, still in EX during its done cycle, from relaunching.
- IDLE:
  - On `acc`: latch op and signedness; latch operand magnitudes (two's-complement absolute value for signed ops, raw value for unsigned); latch sign(s); clear the 6-bit counter; go to RUN.
  - On `start` & func MTHI/MTLO & !`done`: `hi`/`lo` ← `a` at the next edge; no busy; no done pulse.
- RUN, multiply: 64-bit {P,multiplier} shift-add; one multiplier bit per cycle.
- RUN, divide: restoring; one quotient bit per cycle.
- RUN exits to FIX after exactly 32 iterations (counter 0..31).
- FIX:
  - Apply sign corrections: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Write HI/LO: MULT → {HI,LO} = 64-bit product; DIV → LO = quotient, HI = remainder.
  - Set `done`; return to IDLE.
- Arithmetic: signed magnitude of 0x80000000 is 2^31 (33-bit internal width or unsigned 32-bit treatment). Results wrap to 32 bits, so DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero: still takes full latency. In FIX, HI/LO are left unchanged and `dz` = 1 together with `done`.
- `busy` = (state ≠ IDLE) | `acc`.
- Unrecognized `func` with `start`: no effect.

## Timing
- Edge E0 samples `acc` → RUN.
- E1..E32: iterations → FIX.
- E33: HI/LO written; `done` high for the cycle E33–E34.
- `busy` is high for 34 cycles: the start cycle, 32 RUN cycles, and FIX. It is low in the done cycle, so the instruction leaves EX at E34. Back-to-back MDU ops: the next one is accepted at E34 at the earliest.
- MTHI/MTLO: 1-cycle write, visible in the cycle after the edge.
- `start` during RUN/FIX is ignored; the pipeline is stalled.
- Reset at any time:
  - State IDLE, counter 0.
  - `hi` = `lo` = 0; `done` = `dz` = 0; `busy` = 0 unless `acc` in the following cycle.
  - An in-flight operation is discarded.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU supported as above.
- `MDU_DIV_EN` undefined:
  - Divide datapath removed.
  - DIV/DIVU are unrecognized funcs: no busy, HI/LO unchanged, no `done`.
  - `dz` tied to 0.
  - MULT/MULTU/MTHI/MTLO unchanged.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy 34 cycles, `done` at E33, HI=0xFFFFFFFE LO=0x00000001.
- MULT a=0xFFFFFFFD (−3) b=5 → HI=0xFFFFFFFF LO=0xFFFFFFF1. Hold `start` through the done cycle → no relaunch.
- DIV a=0xFFFFFFF9 (−7) b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- MTHI a=0x12345678, then DIV a=5 b=0 → `dz`=1 with `done` after 34 cycles; HI=0x12345678, LO unchanged.
- MULTU in flight; assert `rst` at RUN iteration 10 → next cycle IDLE, busy=0, HI=LO=0, no `done`.
- Without `MDU_DIV_EN`: DIV a=9 b=3 → busy=0, HI/LO unchanged; MULT 6×7 → LO=42, HI=0.
